// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store initiator between the execute stage and a word-wide data memory.
// Accepts one request at a time, checks funct3 / alignment / range, issues the
// memory cycle(s) and returns a single result. Sub-word stores are done as a
// read-modify-write because the memory only writes whole words. Sub-word loads
// are lane-selected and sign/zero-extended following RV32I funct3.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_store           1 = store, 0 = load
//   req_funct3          RV32I width/sign code
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   resp_valid/ready    response handshake, response held until taken
//   resp_rdata          extended load data, 0 for stores and errors
//   resp_err            misaligned, illegal funct3 or out-of-range
//   mem_read/mem_write  memory strobes, decoded from the state register only
//   mem_addr            word-aligned memory address
//   mem_wdata           memory write data
//   mem_rdata           memory read data, combinational with mem_read
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_STORE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    state_t      state_r;
    state_t      state_next_s;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] word_r;     // store data, replaced by the merged word after RMW read
    logic [31:0] rdata_r;
    logic        err_r;

    logic        f3_legal_s;
    logic        misalign_s;
    logic        range_err_s;
    logic        req_err_s;

    // Select the addressed byte/half of a word and extend it as funct3 asks.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = word;
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Overlay the right-aligned store data onto the old word at the addressed lane.
    function automatic logic [31:0] merge_store(input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [31:0] old_word,
                                                input logic [31:0] wdata);
        logic [31:0] res;
        res = old_word;
        case (f3)
            3'b000: begin
                case (lane)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    2'd3:    res[31:24] = wdata[7:0];
                    default: res = old_word;
                endcase
            end
            3'b001: begin
                if (lane[1]) begin
                    res[31:16] = wdata[15:0];
                end else begin
                    res[15:0] = wdata[15:0];
                end
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Request legality: funct3 code, natural alignment and memory range.
    always_comb begin
        f3_legal_s  = 1'b0;
        misalign_s  = 1'b0;
        range_err_s = 1'b0;
        if (req_store) begin
            f3_legal_s = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                         (req_funct3 == 3'b010);
        end else begin
            f3_legal_s = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                         (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                         (req_funct3 == 3'b101);
        end
        if (req_funct3[1:0] == 2'b01) begin
            misalign_s = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misalign_s = (req_addr[1:0] != 2'b00);
        end else begin
            misalign_s = 1'b0;
        end
        if (CHECK_RANGE) begin
            range_err_s = (req_addr >= ADDR_LIMIT);
        end else begin
            range_err_s = 1'b0;
        end
        req_err_s = !f3_legal_s || misalign_s || range_err_s;
    end

    // State register; reset drops straight to IDLE, discarding any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!req_valid) begin
                    state_next_s = ST_IDLE;
                end else if (req_err_s) begin
                    state_next_s = ST_RESP;
                end else if (!req_store) begin
                    state_next_s = ST_LOAD;
                end else if (req_funct3[1:0] == 2'b10) begin
                    state_next_s = ST_STORE;
                end else begin
                    state_next_s = ST_RMW_RD;
                end
            end
            ST_LOAD:   state_next_s = ST_RESP;
            ST_RMW_RD: state_next_s = ST_STORE;
            ST_STORE:  state_next_s = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Request capture, load extension and RMW merge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            funct3_r <= 3'b000;
            addr_r   <= 32'h0000_0000;
            word_r   <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        funct3_r <= req_funct3;
                        addr_r   <= req_addr;
                        word_r   <= req_wdata;
                        rdata_r  <= 32'h0000_0000;
                        err_r    <= req_err_s;
                    end
                end
                ST_LOAD:   rdata_r <= load_extend(funct3_r, addr_r[1:0], mem_rdata);
                ST_RMW_RD: word_r  <= merge_store(funct3_r, addr_r[1:0], mem_rdata, word_r);
                default: begin
                end
            endcase
        end
    end

    // Output decode from the state register and captured registers.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0000_0000;
        resp_err   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 32'h0000_0000;
        mem_wdata  = 32'h0000_0000;
        case (state_r)
            ST_IDLE: req_ready = 1'b1;
            ST_LOAD, ST_RMW_RD: begin
                mem_read = 1'b1;
                mem_addr = {addr_r[31:2], 2'b00};
            end
            ST_STORE: begin
                mem_write = 1'b1;
                mem_addr  = {addr_r[31:2], 2'b00};
                mem_wdata = word_r;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_r;
                resp_err   = err_r;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 256-word behavioural data memory.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    int rd_total = 0;
    int wr_total = 0;
    int n_vec = 0;
    int n_err = 0;

    lsu_mem_ctrl #(.DEPTH_WORDS(256), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_read) rd_total <= rd_total + 1;
        if (mem_write) begin
            wr_total <= wr_total + 1;
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    // Issue one request with resp_ready high; report result, latency and memory cycles.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output logic err, output int lat, output int nrd, output int nwr);
        int rd0, wr0;
        @(negedge clk);
        rd0 = rd_total; wr0 = wr_total;
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_vec++;
        if (resp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL resp_timeout addr=%h: resp_valid got %b want 1", a, resp_valid);
        end
        rdata = resp_rdata;
        err = resp_err;
        @(posedge clk); #1;
        nrd = rd_total - rd0;
        nwr = wr_total - wr0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want 10000",
                     {req_ready, resp_valid, resp_err, mem_read, mem_write});
        end
        n_vec++;
        if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_data got %h want 0", {resp_rdata, mem_addr, mem_wdata});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, nrd, nwr);
        n_vec++;
        if ({er, rd, 8'(lat), 8'(nrd), 8'(nwr)} !== {1'b0, 32'h0, 8'd2, 8'd0, 8'd1}) begin
            n_err++;
            $display("FAIL sw_0x10 err/rdata/lat/rd/wr got %b %h %0d %0d %0d want 0 0 2 0 1",
                     er, rd, lat, nrd, nwr);
        end
        n_vec++;
        if (mem[4] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL sw_mem got %h want deadbeef", mem[4]);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nrd, nwr);
        n_vec++;
        if ({er, rd, 8'(lat), 8'(nrd), 8'(nwr)} !== {1'b0, 32'hDEADBEEF, 8'd2, 8'd1, 8'd0}) begin
            n_err++;
            $display("FAIL lw_0x10 err/rdata/lat/rd/wr got %b %h %0d %0d %0d want 0 deadbeef 2 1 0",
                     er, rd, lat, nrd, nwr);
        end
    endtask

    task automatic test_sub_store();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        do_req(1'b1, 3'b000, 32'h12, 32'h00000055, rd, er, lat, nrd, nwr);
        n_vec++;
        if ({er, 8'(lat), 8'(nrd), 8'(nwr), mem[4]} !== {1'b0, 8'd3, 8'd1, 8'd1, 32'hDE55BEEF}) begin
            n_err++;
            $display("FAIL sb_0x12 err/lat/rd/wr/mem got %b %0d %0d %0d %h want 0 3 1 1 de55beef",
                     er, lat, nrd, nwr, mem[4]);
        end
        do_req(1'b1, 3'b001, 32'h10, 32'hAAAACAFE, rd, er, lat, nrd, nwr);
        n_vec++;
        if ({er, 8'(lat), 8'(nrd), 8'(nwr), mem[4]} !== {1'b0, 8'd3, 8'd1, 8'd1, 32'hDE55CAFE}) begin
            n_err++;
            $display("FAIL sh_0x10 err/lat/rd/wr/mem got %b %0d %0d %0d %h want 0 3 1 1 de55cafe",
                     er, lat, nrd, nwr, mem[4]);
        end
    endtask

    task automatic test_sub_load();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        logic [2:0]  f3 [5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] ad [5]  = '{32'h12, 32'h13, 32'h12, 32'h10, 32'h11};
        logic [31:0] ex [5]  = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                                 32'h00007F01, 32'h0000007F};
        do_req(1'b1, 3'b010, 32'h10, 32'h80FF7F01, rd, er, lat, nrd, nwr);
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3[i], ad[i], 32'h0, rd, er, lat, nrd, nwr);
            n_vec++;
            if ({er, rd, 8'(lat)} !== {1'b0, ex[i], 8'd2}) begin
                n_err++;
                $display("FAIL subload f3=%b addr=%h err/rdata/lat got %b %h %0d want 0 %h 2",
                         f3[i], ad[i], er, rd, lat, ex[i]);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat, nrd, nwr;
        logic        st [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [6] = '{3'b010, 3'b001, 3'b011, 3'b010, 3'b100, 3'b010};
        logic [31:0] ad [6] = '{32'h11, 32'h13, 32'h10, 32'h400, 32'h10, 32'h3FC};
        logic        ee [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int          el [6] = '{1, 1, 1, 1, 1, 2};
        int          er_ [6] = '{0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 6; i++) begin
            do_req(st[i], f3[i], ad[i], 32'h12345678, rd, er, lat, nrd, nwr);
            n_vec++;
            if ({er, 8'(lat), 8'(nrd), 8'(nwr)} !== {ee[i], 8'(el[i]), 8'(er_[i]), 8'd0} ||
                (ee[i] && rd !== 32'h0)) begin
                n_err++;
                $display("FAIL err_case st=%b f3=%b addr=%h err/lat/rd/wr/rdata got %b %0d %0d %0d %h want %b %0d %0d 0",
                         st[i], f3[i], ad[i], er, lat, nrd, nwr, rd, ee[i], el[i], er_[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int wr0;
        @(negedge clk);
        wr0 = wr_total;
        req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        // A competing store stays valid while busy; it must be ignored.
        req_store = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h80FF7F01}) begin
                n_err++;
                $display("FAIL hold_cycle%0d valid/ready/err/rdata got %b %b %b %h want 1 0 0 80ff7f01",
                         i, resp_valid, req_ready, resp_err, resp_rdata);
            end
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({req_ready, resp_valid, 8'(wr_total - wr0)} !== {1'b1, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL hold_release ready/valid/writes got %b %b %0d want 1 0 0",
                     req_ready, resp_valid, wr_total - wr0);
        end
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] rd; logic er; int lat, nrd, nwr, wr0;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat, nrd, nwr);
        @(negedge clk);
        wr0 = wr_total;
        req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h12; req_wdata = 32'h55;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_vec++;
        if (mem_read !== 1'b1) begin
            n_err++;
            $display("FAIL rmw_rd_entered mem_read got %b want 1", mem_read);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({mem_read, mem_write, req_ready, resp_valid} !== 4'b0010) begin
            n_err++;
            $display("FAIL async_reset rd/wr/ready/valid got %b want 0010",
                     {mem_read, mem_write, req_ready, resp_valid});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({mem[4], 8'(wr_total - wr0), req_ready, resp_valid} !== {32'hDEADBEEF, 8'd0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_rmw mem/writes/ready/valid got %h %0d %b %b want deadbeef 0 1 0",
                     mem[4], wr_total - wr0, req_ready, resp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_sub_store();
        test_sub_load();
        test_errors();
        test_backpressure();
        test_reset_mid_rmw();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
